// File: rtl/timer_display_scan_pkg.sv
// Shared constants for the timer display scanner: segment patterns,
// digit indices and the scan phase encoding.
package timer_display_scan_pkg;

    // Segment bit order is {a, b, c, d, e, f, g}, active high.
    localparam logic [6:0] SEG_0    = 7'h7E;
    localparam logic [6:0] SEG_1    = 7'h30;
    localparam logic [6:0] SEG_2    = 7'h6D;
    localparam logic [6:0] SEG_3    = 7'h79;
    localparam logic [6:0] SEG_4    = 7'h33;
    localparam logic [6:0] SEG_5    = 7'h5B;
    localparam logic [6:0] SEG_6    = 7'h5F;
    localparam logic [6:0] SEG_7    = 7'h70;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h7B;
    localparam logic [6:0] SEG_DASH = 7'h01;

    localparam logic [1:0] DIG_SEC0 = 2'd0;
    localparam logic [1:0] DIG_SEC1 = 2'd1;
    localparam logic [1:0] DIG_MIN0 = 2'd2;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_t;

    function automatic logic [2:0] digit_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-7-segment decoder; anything above 9 shows a dash.
module seg7_decode
    import timer_display_scan_pkg::*;
#(
    parameter int DIGIT_W = 6
) (
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [6:0]         o_seg
);

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_seg = SEG_DASH;
        if (i_digit <= DIGIT_W'(9)) begin
            case (i_digit[3:0])
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/timer_display_scan.sv
// Time-multiplexed 3-digit 7-segment driver for the playback Timer: per-frame
// snapshot, blanking cycle between digits, and whole-display blink while paused.
module timer_display_scan
    import timer_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 2,
    parameter int DIGIT_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               paused,
    input  logic [DIGIT_W-1:0] seconds0,
    input  logic [DIGIT_W-1:0] seconds1,
    input  logic [DIGIT_W-1:0] minutes0,
    output logic [6:0]         segments,
    output logic [2:0]         digit_en,
    output logic               dp,
    output logic               range_err
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    phase_t             r_phase;
    logic [1:0]         r_idx;
    logic [DW-1:0]      r_dwell;
    logic               r_armed;
    logic [FW-1:0]      r_frame;
    logic               r_blink;
    logic [DIGIT_W-1:0] r_snap_s0;
    logic [DIGIT_W-1:0] r_snap_s1;
    logic [DIGIT_W-1:0] r_snap_m0;
    logic               r_range_err;
    logic [6:0]         r_segments;
    logic [2:0]         r_digit_en;
    logic               r_dp;

    phase_t             w_phase_nxt;
    logic [1:0]         w_idx_nxt;
    logic [DW-1:0]      w_dwell_nxt;
    logic [FW-1:0]      w_frame_nxt;
    logic               w_blink_nxt;
    logic               w_dwell_last;
    logic               w_boundary;
    logic               w_visible;
    logic [DIGIT_W-1:0] w_digit_sel;
    logic [6:0]         w_seg;

    assign w_dwell_last = (r_dwell == DW'(SCAN_DIV - 1));
    // The first edge out of reset is treated as a frame start so a snapshot is taken at once.
    assign w_boundary   = !r_armed ||
                          ((r_phase == SHOW) && (r_idx == DIG_MIN0) && w_dwell_last);

    always_comb begin
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        if (!r_armed) begin
            w_phase_nxt = BLANK;
            w_idx_nxt   = DIG_SEC0;
            w_dwell_nxt = '0;
        end else if (r_phase == BLANK) begin
            w_phase_nxt = SHOW;
            w_dwell_nxt = '0;
        end else if (w_dwell_last) begin
            w_phase_nxt = BLANK;
            w_dwell_nxt = '0;
            w_idx_nxt   = (r_idx == DIG_MIN0) ? DIG_SEC0 : r_idx + 2'd1;
        end else begin
            w_dwell_nxt = r_dwell + DW'(1);
        end
    end

    always_comb begin
        w_frame_nxt = r_frame;
        w_blink_nxt = r_blink;
        if (!paused) begin
            w_frame_nxt = '0;
            w_blink_nxt = 1'b0;
        end else if (w_boundary) begin
            if (r_frame == FW'(BLINK_DIV - 1)) begin
                w_frame_nxt = '0;
                w_blink_nxt = !r_blink;
            end else begin
                w_frame_nxt = r_frame + FW'(1);
            end
        end
    end

    // Outputs are registered from next-state values so they line up with the FSM phase.
    always_comb begin
        case (w_idx_nxt)
            DIG_SEC1: w_digit_sel = r_snap_s1;
            DIG_MIN0: w_digit_sel = r_snap_m0;
            default:  w_digit_sel = r_snap_s0;
        endcase
    end

    seg7_decode #(.DIGIT_W(DIGIT_W)) u_decode (
        .i_digit (w_digit_sel),
        .o_seg   (w_seg)
    );

    assign w_visible = (w_phase_nxt == SHOW) && !w_blink_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= BLANK;
            r_idx       <= DIG_SEC0;
            r_dwell     <= '0;
            r_armed     <= 1'b0;
            r_frame     <= '0;
            r_blink     <= 1'b0;
            r_snap_s0   <= '0;
            r_snap_s1   <= '0;
            r_snap_m0   <= '0;
            r_range_err <= 1'b0;
            r_segments  <= '0;
            r_digit_en  <= '0;
            r_dp        <= 1'b0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_idx      <= w_idx_nxt;
            r_dwell    <= w_dwell_nxt;
            r_armed    <= 1'b1;
            r_frame    <= w_frame_nxt;
            r_blink    <= w_blink_nxt;
            r_segments <= (w_phase_nxt == SHOW) ? w_seg : 7'h00;
            r_digit_en <= w_visible ? digit_onehot(w_idx_nxt) : 3'b000;
            r_dp       <= w_visible && (w_idx_nxt == DIG_MIN0);
            if (w_boundary) begin
                r_snap_s0   <= seconds0;
                r_snap_s1   <= seconds1;
                r_snap_m0   <= minutes0;
                r_range_err <= (seconds0 > DIGIT_W'(9)) ||
                               (seconds1 > DIGIT_W'(9)) ||
                               (minutes0 > DIGIT_W'(9));
            end
        end
    end

    assign segments  = r_segments;
    assign digit_en  = r_digit_en;
    assign dp        = r_dp;
    assign range_err = r_range_err;

endmodule

// File: tb/tb_timer_display_scan.sv
// Directed bench for timer_display_scan: reset/first-frame vector table, then
// hand-written frame sequences for snapshot, range error, blink and mid-run reset.
module tb_timer_display_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       paused;
    logic [5:0] seconds0;
    logic [5:0] seconds1;
    logic [5:0] minutes0;
    logic [6:0] segments;
    logic [2:0] digit_en;
    logic       dp;
    logic       range_err;

    int n_vec = 0;
    int n_err = 0;

    timer_display_scan #(.SCAN_DIV(4), .BLINK_DIV(2), .DIGIT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .paused    (paused),
        .seconds0  (seconds0),
        .seconds1  (seconds1),
        .minutes0  (minutes0),
        .segments  (segments),
        .digit_en  (digit_en),
        .dp        (dp),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        pau;
        logic [5:0]  s0;
        logic [5:0]  s1;
        logic [5:0]  m0;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {segments, digit_en, dp, range_err} at frame position p (0..14).
    // Positions 0, 5, 10 are blanking; digit i is lit at positions 5*i+1 .. 5*i+4.
    function automatic logic [11:0] pos_out(input int p, input logic [6:0] e0,
                                            input logic [6:0] e1, input logic [6:0] e2,
                                            input int vis_from, input logic err);
        logic [6:0] seg;
        logic [2:0] en;
        logic       d;
        int         i;
        if (p % 5 == 0) return {7'h00, 3'b000, 1'b0, err};
        i   = p / 5;
        seg = (i == 0) ? e0 : (i == 1) ? e1 : e2;
        en  = (p >= vis_from) ? (3'b001 << i) : 3'b000;
        d   = (p >= vis_from) && (i == 2);
        return {seg, en, d, err};
    endfunction

    task automatic check(input string name, input int p, input logic [11:0] exp);
        logic [11:0] got;
        got = {segments, digit_en, dp, range_err};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s pos %0d: got seg=%h en=%b dp=%b err=%b, want seg=%h en=%b dp=%b err=%b",
                     name, p, got[11:5], got[4:2], got[1], got[0],
                     exp[11:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Checks n_pos positions of a frame starting at its blanking cycle; after the
    // check at position chg_at, new inputs are driven (sampled on the next edge).
    task automatic run_frame(input string name, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input int vis_from, input logic err,
                             input int chg_at, input logic [5:0] n_s0, input logic [5:0] n_s1,
                             input logic [5:0] n_m0, input logic n_pau, input int n_pos);
        for (int p = 0; p < n_pos; p++) begin
            check(name, p, pos_out(p, e0, e1, e2, vis_from, err));
            if (p == chg_at) begin
                seconds0 = n_s0;
                seconds1 = n_s1;
                minutes0 = n_m0;
                paused   = n_pau;
            end
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        paused   = 1'b0;
        seconds0 = 6'd5;
        seconds1 = 6'd4;
        minutes0 = 6'd3;

        // Three reset cycles, then the first frame of 3:45 and the next frame start.
        for (int i = 0; i < 3; i++)
            tbl[i] = '{rst: 1'b1, pau: 1'b0, s0: 6'd5, s1: 6'd4, m0: 6'd3, exp: 12'h000};
        for (int k = 0; k < 16; k++)
            tbl[3 + k] = '{rst: 1'b0, pau: 1'b0, s0: 6'd5, s1: 6'd4, m0: 6'd3,
                           exp: pos_out(k, 7'h5B, 7'h33, 7'h79, 0, 1'b0)};

        for (int i = 0; i < 19; i++) begin
            reset    = tbl[i].rst;
            paused   = tbl[i].pau;
            seconds0 = tbl[i].s0;
            seconds1 = tbl[i].s1;
            minutes0 = tbl[i].m0;
            tick();
            check("table", i, tbl[i].exp);
        end

        // seconds0 changes during digit 1 of this frame; only the next frame sees it.
        run_frame("snap_hold", 7'h5B, 7'h33, 7'h79, 0, 1'b0, 7, 6'd6, 6'd4, 6'd3, 1'b0, 15);
        run_frame("new_s0",    7'h5F, 7'h33, 7'h79, 0, 1'b0, 3, 6'd6, 6'd12, 6'd3, 1'b0, 15);
        run_frame("range_err", 7'h5F, 7'h01, 7'h79, 0, 1'b1, 3, 6'd6, 6'd4, 6'd3, 1'b0, 15);
        // Range error clears at this frame start; paused rises mid-frame.
        run_frame("err_clear", 7'h5F, 7'h33, 7'h79, 0, 1'b0, 3, 6'd6, 6'd4, 6'd3, 1'b1, 15);
        run_frame("blink_v1",  7'h5F, 7'h33, 7'h79, 0,  1'b0, -1, 6'd6, 6'd4, 6'd3, 1'b1, 15);
        run_frame("blink_d1",  7'h5F, 7'h33, 7'h79, 15, 1'b0, -1, 6'd6, 6'd4, 6'd3, 1'b1, 15);
        run_frame("blink_d2",  7'h5F, 7'h33, 7'h79, 15, 1'b0, -1, 6'd6, 6'd4, 6'd3, 1'b1, 15);
        run_frame("blink_v2",  7'h5F, 7'h33, 7'h79, 0,  1'b0, -1, 6'd6, 6'd4, 6'd3, 1'b1, 15);
        run_frame("blink_v3",  7'h5F, 7'h33, 7'h79, 0,  1'b0, -1, 6'd6, 6'd4, 6'd3, 1'b1, 15);
        // Dark frame; paused drops during digit 0 and the display returns on the next cycle.
        run_frame("unpause",   7'h5F, 7'h33, 7'h79, 3,  1'b0, 2, 6'd6, 6'd4, 6'd3, 1'b0, 15);

        // Run into the SHOW of digit 2, then reset mid-frame with new inputs 7:08.
        run_frame("pre_reset", 7'h5F, 7'h33, 7'h79, 0, 1'b0, -1, 6'd6, 6'd4, 6'd3, 1'b0, 12);
        reset    = 1'b1;
        seconds0 = 6'd8;
        seconds1 = 6'd0;
        minutes0 = 6'd7;
        tick();
        check("reset_mid", 0, 12'h000);
        tick();
        check("reset_hold", 1, 12'h000);
        reset = 1'b0;
        tick();
        run_frame("after_reset", 7'h7F, 7'h7E, 7'h70, 0, 1'b0, 3, 6'd9, 6'd2, 6'd1, 1'b0, 15);
        run_frame("digits_921",  7'h7B, 7'h6D, 7'h30, 0, 1'b0, -1, 6'd9, 6'd2, 6'd1, 1'b0, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
